// File: rtl/demuxl2_pkg.sv
// Shared constants and types for the MUXL2 receiver-side unstriper.
package demuxl2_pkg;

   localparam int DATA_W     = 8;
   localparam int IDLE_CNT_W = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   localparam logic SLOT_00 = 1'b0;
   localparam logic SLOT_11 = 1'b1;

endpackage

// File: rtl/demuxl2_unstripe.sv
// Rebuilds lanes 00/11 from the full-rate interleaved MUXL2 stream; slot 0 is
// the first valid word after alignment, and a watchdog drops alignment on idle.
module demuxl2_unstripe #(
   parameter int DATA_W     = demuxl2_pkg::DATA_W,
   parameter int IDLE_PAIRS = 4
) (
   input  logic              clk_4f,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_000,
   input  logic              valid_000,
   output logic [DATA_W-1:0] data_00,
   output logic [DATA_W-1:0] data_11,
   output logic              valid_00,
   output logic              valid_11,
   output logic              pair_stb,
   output logic              aligned
);
   import demuxl2_pkg::*;

   localparam logic [IDLE_CNT_W-1:0] CNT_ONE = IDLE_CNT_W'(1);
   localparam logic [IDLE_CNT_W-1:0] CNT_MAX = IDLE_CNT_W'(IDLE_PAIRS - 1);

   state_e                  state_q, state_d;
   logic                    slot_q, slot_d;
   logic [DATA_W-1:0]       hold0_q, hold0_d;
   logic                    hold_v_q, hold_v_d;
   logic [IDLE_CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic [DATA_W-1:0]       data_00_q, data_00_d;
   logic [DATA_W-1:0]       data_11_q, data_11_d;
   logic                    valid_00_q, valid_00_d;
   logic                    valid_11_q, valid_11_d;
   logic                    pair_stb_q, pair_stb_d;
   logic                    aligned_q, aligned_d;

   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      hold0_d    = hold0_q;
      hold_v_d   = hold_v_q;
      idle_cnt_d = idle_cnt_q;
      data_00_d  = data_00_q;
      data_11_d  = data_11_q;
      valid_00_d = valid_00_q;
      valid_11_d = valid_11_q;
      pair_stb_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (valid_000) begin
               hold0_d  = data_000;
               hold_v_d = 1'b1;
               state_d  = ACTIVE;
               slot_d   = SLOT_11;
            end
         end
         ACTIVE: begin
            if (slot_q == SLOT_00) begin
               if (valid_000) hold0_d = data_000;
               hold_v_d = valid_000;
               slot_d   = SLOT_11;
            end else begin
               valid_00_d = hold_v_q;
               valid_11_d = valid_000;
               if (hold_v_q)  data_00_d = hold0_q;
               if (valid_000) data_11_d = data_000;
               pair_stb_d = 1'b1;
               slot_d     = SLOT_00;
               // Only a pair with no valid word at all feeds the watchdog.
               if (!hold_v_q && !valid_000) begin
                  if (idle_cnt_q == CNT_MAX) begin
                     state_d    = IDLE;
                     idle_cnt_d = '0;
                  end else begin
                     idle_cnt_d = idle_cnt_q + CNT_ONE;
                  end
               end else begin
                  idle_cnt_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      aligned_d = (state_d == ACTIVE);
   end

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         state_q    <= IDLE;
         slot_q     <= SLOT_00;
         hold0_q    <= '0;
         hold_v_q   <= 1'b0;
         idle_cnt_q <= '0;
         data_00_q  <= '0;
         data_11_q  <= '0;
         valid_00_q <= 1'b0;
         valid_11_q <= 1'b0;
         pair_stb_q <= 1'b0;
         aligned_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         hold0_q    <= hold0_d;
         hold_v_q   <= hold_v_d;
         idle_cnt_q <= idle_cnt_d;
         data_00_q  <= data_00_d;
         data_11_q  <= data_11_d;
         valid_00_q <= valid_00_d;
         valid_11_q <= valid_11_d;
         pair_stb_q <= pair_stb_d;
         aligned_q  <= aligned_d;
      end
   end

   assign data_00  = data_00_q;
   assign data_11  = data_11_q;
   assign valid_00 = valid_00_q;
   assign valid_11 = valid_11_q;
   assign pair_stb = pair_stb_q;
   assign aligned  = aligned_q;

endmodule

// File: tb/tb_demuxl2_unstripe.sv
// Directed bench for demuxl2_unstripe: expected pairs are queued as stimulus is
// written and popped whenever the DUT is expected to strobe a pair.
module tb_demuxl2_unstripe;

   localparam int DATA_W = 8;

   typedef struct {
      logic [DATA_W-1:0] d00;
      logic [DATA_W-1:0] d11;
      logic              v00;
      logic              v11;
   } pair_t;

   logic              clk_4f = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] data_000;
   logic              valid_000;
   logic [DATA_W-1:0] data_00;
   logic [DATA_W-1:0] data_11;
   logic              valid_00;
   logic              valid_11;
   logic              pair_stb;
   logic              aligned;

   int    n_cmp  = 0;
   int    n_fail = 0;
   pair_t exp_q[$];
   pair_t cur;

   demuxl2_unstripe #(.DATA_W(DATA_W), .IDLE_PAIRS(4)) dut (
      .clk_4f   (clk_4f),
      .reset    (reset),
      .data_000 (data_000),
      .valid_000(valid_000),
      .data_00  (data_00),
      .data_11  (data_11),
      .valid_00 (valid_00),
      .valid_11 (valid_11),
      .pair_stb (pair_stb),
      .aligned  (aligned)
   );

   always #5 clk_4f = ~clk_4f;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [7:0] d00, input logic [7:0] d11,
                       input logic v00, input logic v11);
      pair_t p;
      p.d00 = d00; p.d11 = d11; p.v00 = v00; p.v11 = v11;
      exp_q.push_back(p);
   endtask

   task automatic check_outs();
      chk("data_00",  32'(data_00),  32'(cur.d00));
      chk("data_11",  32'(data_11),  32'(cur.d11));
      chk("valid_00", 32'(valid_00), 32'(cur.v00));
      chk("valid_11", 32'(valid_11), 32'(cur.v11));
   endtask

   // One clk_4f cycle: drive the slot word, then check strobe, alignment and
   // the presented pair (which must stay put between strobes).
   task automatic step(input logic v, input logic [7:0] d, input logic stb, input logic al);
      valid_000 = v;
      data_000  = d;
      @(posedge clk_4f);
      #1;
      chk("pair_stb", 32'(pair_stb), 32'(stb));
      chk("aligned",  32'(aligned),  32'(al));
      if (stb) begin
         n_cmp++;
         assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0d expected >0", exp_q.size());
         end
         if (exp_q.size() > 0) cur = exp_q.pop_front();
      end
      check_outs();
   endtask

   task automatic rst_step(input logic v, input logic [7:0] d);
      reset     = 1'b1;
      valid_000 = v;
      data_000  = d;
      @(posedge clk_4f);
      #1;
      reset = 1'b0;
      cur.d00 = '0; cur.d11 = '0; cur.v00 = 1'b0; cur.v11 = 1'b0;
      chk("rst_pair_stb", 32'(pair_stb), 32'h0);
      chk("rst_aligned",  32'(aligned),  32'h0);
      check_outs();
   endtask

   function automatic logic [7:0] junk();
      return 8'($urandom);
   endfunction

   initial begin
      reset = 1'b0; valid_000 = 1'b0; data_000 = '0;
      cur.d00 = '0; cur.d11 = '0; cur.v00 = 1'b0; cur.v11 = 1'b0;

      // Reset, then idle input
      rst_step(1'b0, 8'h00);
      rst_step(1'b0, 8'h00);
      for (int i = 0; i < 10; i++) step(1'b0, junk(), 1'b0, 1'b0);

      // Alignment and pair rebuild
      step(1'b1, 8'hFF, 1'b0, 1'b1); push(8'hFF, 8'hDD, 1'b1, 1'b1); step(1'b1, 8'hDD, 1'b1, 1'b1);
      step(1'b1, 8'hEE, 1'b0, 1'b1); push(8'hEE, 8'hCC, 1'b1, 1'b1); step(1'b1, 8'hCC, 1'b1, 1'b1);
      step(1'b1, 8'hBB, 1'b0, 1'b1); push(8'hBB, 8'h99, 1'b1, 1'b1); step(1'b1, 8'h99, 1'b1, 1'b1);
      step(1'b1, 8'hAA, 1'b0, 1'b1); push(8'hAA, 8'h88, 1'b1, 1'b1); step(1'b1, 8'h88, 1'b1, 1'b1);

      // Partial pair: lane 00 keeps AA
      step(1'b0, 8'h10, 1'b0, 1'b1); push(8'hAA, 8'h77, 1'b0, 1'b1); step(1'b1, 8'h77, 1'b1, 1'b1);

      // Watchdog expiry on the 4th empty pair, then realign
      for (int i = 0; i < 4; i++) begin
         step(1'b0, junk(), 1'b0, 1'b1);
         push(8'hAA, 8'h77, 1'b0, 1'b0);
         step(1'b0, junk(), 1'b1, (i < 3));
      end
      step(1'b0, junk(), 1'b0, 1'b0);
      step(1'b1, 8'h1F, 1'b0, 1'b1); push(8'h1F, 8'h5E, 1'b1, 1'b1); step(1'b1, 8'h5E, 1'b1, 1'b1);

      // Reset mid-pair discards the held slot 0 word, even with valid input
      step(1'b1, 8'h1F, 1'b0, 1'b1);
      rst_step(1'b1, 8'h33);
      step(1'b0, junk(), 1'b0, 1'b0);
      step(1'b1, 8'h42, 1'b0, 1'b1); push(8'h42, 8'h24, 1'b1, 1'b1); step(1'b1, 8'h24, 1'b1, 1'b1);

      // Watchdog clear: a lane 11 word restarts the count
      for (int i = 0; i < 3; i++) begin
         step(1'b0, junk(), 1'b0, 1'b1); push(8'h42, 8'h24, 1'b0, 1'b0); step(1'b0, junk(), 1'b1, 1'b1);
      end
      step(1'b0, junk(), 1'b0, 1'b1); push(8'h42, 8'h5E, 1'b0, 1'b1); step(1'b1, 8'h5E, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, junk(), 1'b0, 1'b1); push(8'h42, 8'h5E, 1'b0, 1'b0); step(1'b0, junk(), 1'b1, 1'b1);
      end
      step(1'b0, junk(), 1'b0, 1'b1); push(8'h42, 8'h5E, 1'b0, 1'b0); step(1'b0, junk(), 1'b1, 1'b0);
      step(1'b0, junk(), 1'b0, 1'b0);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
